// File: rtl/mastermind_pkg.sv
// Shared definitions for the Mastermind game sequencer: state encoding,
// per-slot result codes and default geometry.
package mastermind_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EDIT    = 3'd1,
    S_EXACT   = 3'd2,
    S_PRESENT = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5,
    S_WON     = 3'd6,
    S_LOST    = 3'd7
  } state_e;

  localparam logic [1:0] ST_ABSENT  = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_EXACT   = 2'd2;

  localparam int DEF_NUM_SLOTS  = 4;
  localparam int DEF_NUM_COLORS = 6;
  localparam int DEF_CW         = 3;
  localparam int DEF_NUM_ROWS   = 8;

endpackage

// File: rtl/mastermind_game_fsm_if.sv
// Button inputs and board/score outputs of the game sequencer.
// master = button/board side, slave = the sequencer itself.
interface mastermind_game_fsm_if
  import mastermind_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int CW        = DEF_CW,
  parameter int NUM_ROWS  = DEF_NUM_ROWS
);
  localparam int SW = $clog2(NUM_SLOTS);
  localparam int RW = $clog2(NUM_ROWS);
  localparam int NW = $clog2(NUM_SLOTS + 1);

  logic                    up, down, left, right, center;
  logic [2:0]              state;
  logic [SW-1:0]           cursor;
  logic [RW-1:0]           row;
  logic [NUM_SLOTS*CW-1:0] guess;
  logic                    wr_en;
  logic [RW-1:0]           wr_row;
  logic [SW-1:0]           wr_slot;
  logic [CW-1:0]           wr_color;
  logic [1:0]              wr_status;
  logic                    result_valid;
  logic [NW-1:0]           exact_cnt, present_cnt;
  logic                    won, lost;

  modport master (
    output up, down, left, right, center,
    input  state, cursor, row, guess, wr_en, wr_row, wr_slot, wr_color, wr_status,
    input  result_valid, exact_cnt, present_cnt, won, lost
  );

  modport slave (
    input  up, down, left, right, center,
    output state, cursor, row, guess, wr_en, wr_row, wr_slot, wr_color, wr_status,
    output result_valid, exact_cnt, present_cnt, won, lost
  );

endinterface

// File: rtl/mastermind_lfsr.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) used as the secret source.
module mastermind_lfsr #(
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] value
);
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic [15:0] lfsr_q, lfsr_d;

  // Right-shifting Galois step
  always_comb begin
    if (lfsr_q[0]) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ TAPS;
    end else begin
      lfsr_d = {1'b0, lfsr_q[15:1]};
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/mastermind_game_fsm.sv
// Mastermind game sequencer: edits the guess row, scores it slot-serially, streams results.
// Optional FIXED_SECRET_EN replaces the LFSR secret by the FIXED_SECRET parameter.
module mastermind_game_fsm
  import mastermind_pkg::*;
#(
  parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int NUM_COLORS = DEF_NUM_COLORS,
  parameter int CW         = DEF_CW,
  parameter int NUM_ROWS   = DEF_NUM_ROWS
`ifdef FIXED_SECRET_EN
  ,
  parameter logic [NUM_SLOTS*CW-1:0] FIXED_SECRET = 12'h8D1
`endif
) (
  input logic                  clk,
  input logic                  rst,
  mastermind_game_fsm_if.slave bus
);
  localparam int GW = NUM_SLOTS * CW;
  localparam int SW = $clog2(NUM_SLOTS);
  localparam int RW = $clog2(NUM_ROWS);
  localparam int NW = $clog2(NUM_SLOTS + 1);
  localparam logic [SW-1:0] LAST_SLOT  = SW'(NUM_SLOTS - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0] LAST_COLOR = CW'(NUM_COLORS - 1);
  localparam logic [NW-1:0] ALL_EXACT  = NW'(NUM_SLOTS);

  function automatic logic [NW-1:0] count_status(input logic [NUM_SLOTS-1:0][1:0] st,
                                                 input logic [1:0] code);
    logic [NW-1:0] n;
    n = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (st[k] == code) n = n + NW'(1'b1);
    end
    return n;
  endfunction

  logic [GW-1:0] secret_src_s;
`ifdef FIXED_SECRET_EN
  assign secret_src_s = FIXED_SECRET;
`else
  logic [GW-1:0] raw_secret_s;

  mastermind_lfsr #(.OUT_W(GW)) u_lfsr (.clk(clk), .rst(rst), .value(raw_secret_s));

  // Fold out-of-range LFSR symbols back into the legal colour range
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (int'(raw_secret_s[CW*s +: CW]) >= NUM_COLORS) begin
        secret_src_s[CW*s +: CW] = raw_secret_s[CW*s +: CW] - CW'(NUM_COLORS);
      end else begin
        secret_src_s[CW*s +: CW] = raw_secret_s[CW*s +: CW];
      end
    end
  end
`endif

  state_e                      state_q, state_d;
  logic [SW-1:0]               cursor_q, cursor_d, i_q, i_d, j_q, j_d;
  logic [RW-1:0]               row_q, row_d, wr_row_q, wr_row_d;
  logic [GW-1:0]               guess_q, guess_d, secret_q, secret_d;
  logic [NUM_SLOTS-1:0]        g_used_q, g_used_d, s_used_q, s_used_d;
  logic [NUM_SLOTS-1:0][1:0]   status_q, status_d;
  logic [NW-1:0]               exact_cnt_q, exact_cnt_d, present_cnt_q, present_cnt_d;
  logic                        won_q, won_d, lost_q, lost_d;
  logic                        result_valid_q, result_valid_d, wr_en_q, wr_en_d;
  logic [SW-1:0]               wr_slot_q, wr_slot_d;
  logic [CW-1:0]               wr_color_q, wr_color_d, cur_color_s;
  logic [1:0]                  wr_status_q, wr_status_d;

  assign cur_color_s = guess_q[CW*cursor_q +: CW];

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    cursor_d       = cursor_q;
    row_d          = row_q;
    guess_d        = guess_q;
    secret_d       = secret_q;
    g_used_d       = g_used_q;
    s_used_d       = s_used_q;
    status_d       = status_q;
    i_d            = i_q;
    j_d            = j_q;
    exact_cnt_d    = exact_cnt_q;
    present_cnt_d  = present_cnt_q;
    won_d          = won_q;
    lost_d         = lost_q;
    result_valid_d = 1'b0;
    wr_en_d        = 1'b0;
    wr_row_d       = wr_row_q;
    wr_slot_d      = wr_slot_q;
    wr_color_d     = wr_color_q;
    wr_status_d    = wr_status_q;
    case (state_q)
      S_IDLE: begin
        if (bus.center) begin
          secret_d = secret_src_s;
          guess_d  = '0;
          row_d    = '0;
          cursor_d = '0;
          state_d  = S_EDIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EDIT: begin
        if (bus.center) begin
          g_used_d = '0;
          s_used_d = '0;
          status_d = '0;
          i_d      = '0;
          state_d  = S_EXACT;
        end else if (bus.right) begin
          cursor_d = (cursor_q == LAST_SLOT) ? {SW{1'b0}} : cursor_q + SW'(1'b1);
        end else if (bus.left) begin
          cursor_d = (cursor_q == {SW{1'b0}}) ? LAST_SLOT : cursor_q - SW'(1'b1);
        end else if (bus.up) begin
          guess_d[CW*cursor_q +: CW] = (cur_color_s == LAST_COLOR) ? {CW{1'b0}}
                                                                   : cur_color_s + CW'(1'b1);
        end else if (bus.down) begin
          guess_d[CW*cursor_q +: CW] = (cur_color_s == {CW{1'b0}}) ? LAST_COLOR
                                                                   : cur_color_s - CW'(1'b1);
        end else begin
          state_d = S_EDIT;
        end
      end
      S_EXACT: begin
        if (guess_q[CW*i_q +: CW] == secret_q[CW*i_q +: CW]) begin
          g_used_d[i_q] = 1'b1;
          s_used_d[i_q] = 1'b1;
          status_d[i_q] = ST_EXACT;
        end else begin
          status_d[i_q] = ST_ABSENT;
        end
        if (i_q == LAST_SLOT) begin
          i_d     = '0;
          j_d     = '0;
          state_d = S_PRESENT;
        end else begin
          i_d = i_q + SW'(1'b1);
        end
      end
      S_PRESENT: begin
        // A guess slot pairs with at most one secret slot, lowest j first
        if (!g_used_q[i_q] && !s_used_q[j_q] &&
            guess_q[CW*i_q +: CW] == secret_q[CW*j_q +: CW]) begin
          g_used_d[i_q] = 1'b1;
          s_used_d[j_q] = 1'b1;
          status_d[i_q] = ST_PRESENT;
        end else begin
          status_d[i_q] = status_q[i_q];
        end
        if (j_q == LAST_SLOT) begin
          j_d = '0;
          if (i_q == LAST_SLOT) begin
            i_d         = '0;
            state_d     = S_WRITE;
            wr_en_d     = 1'b1;
            wr_row_d    = row_q;
            wr_slot_d   = '0;
            wr_color_d  = guess_q[CW-1:0];
            wr_status_d = status_d[0];
          end else begin
            i_d = i_q + SW'(1'b1);
          end
        end else begin
          j_d = j_q + SW'(1'b1);
        end
      end
      S_WRITE: begin
        if (i_q == LAST_SLOT) begin
          i_d            = '0;
          state_d        = S_DONE;
          result_valid_d = 1'b1;
          exact_cnt_d    = count_status(status_q, ST_EXACT);
          present_cnt_d  = count_status(status_q, ST_PRESENT);
        end else begin
          i_d         = i_q + SW'(1'b1);
          wr_en_d     = 1'b1;
          wr_slot_d   = i_d;
          wr_color_d  = guess_q[CW*i_d +: CW];
          wr_status_d = status_q[i_d];
        end
      end
      S_DONE: begin
        if (exact_cnt_q == ALL_EXACT) begin
          won_d   = 1'b1;
          state_d = S_WON;
        end else if (row_q == LAST_ROW) begin
          lost_d  = 1'b1;
          state_d = S_LOST;
        end else begin
          row_d    = row_q + RW'(1'b1);
          guess_d  = '0;
          cursor_d = '0;
          state_d  = S_EDIT;
        end
      end
      S_WON, S_LOST: begin
        if (bus.center) begin
          won_d   = 1'b0;
          lost_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cursor_q       <= '0;
      row_q          <= '0;
      guess_q        <= '0;
      secret_q       <= '0;
      g_used_q       <= '0;
      s_used_q       <= '0;
      status_q       <= '0;
      i_q            <= '0;
      j_q            <= '0;
      exact_cnt_q    <= '0;
      present_cnt_q  <= '0;
      won_q          <= 1'b0;
      lost_q         <= 1'b0;
      result_valid_q <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_row_q       <= '0;
      wr_slot_q      <= '0;
      wr_color_q     <= '0;
      wr_status_q    <= ST_ABSENT;
    end else begin
      state_q        <= state_d;
      cursor_q       <= cursor_d;
      row_q          <= row_d;
      guess_q        <= guess_d;
      secret_q       <= secret_d;
      g_used_q       <= g_used_d;
      s_used_q       <= s_used_d;
      status_q       <= status_d;
      i_q            <= i_d;
      j_q            <= j_d;
      exact_cnt_q    <= exact_cnt_d;
      present_cnt_q  <= present_cnt_d;
      won_q          <= won_d;
      lost_q         <= lost_d;
      result_valid_q <= result_valid_d;
      wr_en_q        <= wr_en_d;
      wr_row_q       <= wr_row_d;
      wr_slot_q      <= wr_slot_d;
      wr_color_q     <= wr_color_d;
      wr_status_q    <= wr_status_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.cursor       = cursor_q;
  assign bus.row          = row_q;
  assign bus.guess        = guess_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_row       = wr_row_q;
  assign bus.wr_slot      = wr_slot_q;
  assign bus.wr_color     = wr_color_q;
  assign bus.wr_status    = wr_status_q;
  assign bus.result_valid = result_valid_q;
  assign bus.exact_cnt    = exact_cnt_q;
  assign bus.present_cnt  = present_cnt_q;
  assign bus.won          = won_q;
  assign bus.lost         = lost_q;

endmodule

// File: tb/tb_mastermind_game_fsm.sv
// Self-checking bench for mastermind_game_fsm: edit vectors table, randomized edits and
// guesses scored by a reference model, win/loss/reset corner sequences.
module tb_mastermind_game_fsm;
  import mastermind_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mastermind_game_fsm_if bus ();
  mastermind_game_fsm dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference LFSR state: the value the design samples at the next clock edge
  logic [15:0] lfsr_m;
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
  end

  int sec[4];
  int m_guess[4];
  int cur_g[4];
  int m_cursor, m_row;

  typedef struct {
    logic [4:0]  btn;        // {center,right,left,up,down}
    int          exp_cursor;
    logic [11:0] exp_guess;
  } edit_vec_t;
  edit_vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] m);
    bus.center = m[4]; bus.right = m[3]; bus.left = m[2]; bus.up = m[1]; bus.down = m[0];
    tick();
    bus.center = 1'b0; bus.right = 1'b0; bus.left = 1'b0; bus.up = 1'b0; bus.down = 1'b0;
  endtask

  function automatic int pack_guess();
    int p = 0;
    for (int s = 0; s < 4; s++) p += m_guess[s] << (3 * s);
    return p;
  endfunction

  // Apply one edit-mode pulse set and compare against the priority/wrap model
  task automatic edit_press(input logic [4:0] m);
    drive(m);
    if (m[3])      m_cursor = (m_cursor + 1) % 4;
    else if (m[2]) m_cursor = (m_cursor + 3) % 4;
    else if (m[1]) m_guess[m_cursor] = (m_guess[m_cursor] + 1) % 6;
    else if (m[0]) m_guess[m_cursor] = (m_guess[m_cursor] + 5) % 6;
    check("edit_cursor", int'(bus.cursor), m_cursor);
    check("edit_guess", int'(bus.guess), pack_guess());
  endtask

  task automatic start_game();
    for (int s = 0; s < 4; s++) begin
`ifdef FIXED_SECRET_EN
      sec[s] = s + 1;
`else
      sec[s] = (int'(lfsr_m >> (3 * s)) & 7) % 6;
`endif
    end
    drive(5'b10000);
    m_row = 0; m_cursor = 0;
    for (int s = 0; s < 4; s++) m_guess[s] = 0;
    check("start_state", int'(bus.state), int'(S_EDIT));
    check("start_row", int'(bus.row), 0);
    check("start_guess", int'(bus.guess), 0);
    check("start_cursor", int'(bus.cursor), 0);
    check("start_flags", {bus.won, bus.lost, bus.wr_en, bus.result_valid}, 0);
  endtask

  task automatic enter_guess();
    for (int s = 0; s < 4; s++) begin
      while (m_cursor != s) edit_press(5'b01000);
      while (m_guess[s] != cur_g[s]) edit_press(5'b00010);
    end
  endtask

  // Reference scorer: exact first, then each guess slot takes the lowest free matching secret slot
  task automatic score(output int ex, output int pr, output int st[4]);
    bit gu[4];
    bit su[4];
    ex = 0; pr = 0;
    for (int i = 0; i < 4; i++) begin
      gu[i] = 1'b0; su[i] = 1'b0; st[i] = 0;
    end
    for (int i = 0; i < 4; i++)
      if (cur_g[i] == sec[i]) begin st[i] = 2; gu[i] = 1'b1; su[i] = 1'b1; ex++; end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (!gu[i] && !su[j] && cur_g[i] == sec[j]) begin
          st[i] = 1; gu[i] = 1'b1; su[j] = 1'b1; pr++;
        end
      end
    end
  endtask

  task automatic submit();
    int ex, pr, nw, exp_state;
    int st[4];
    bit seen;
    score(ex, pr, st);
    enter_guess();
    drive(5'b10000);
    seen = 1'b0; nw = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      tick();
      if (bus.wr_en) begin
        if (nw < 4) begin
          check("wr_slot", int'(bus.wr_slot), nw);
          check("wr_color", int'(bus.wr_color), cur_g[nw]);
          check("wr_status", int'(bus.wr_status), st[nw]);
          check("wr_row", int'(bus.wr_row), m_row);
        end
        nw++;
      end
      if (bus.result_valid) begin
        seen = 1'b1;
        check("result_latency", n, 24);
        check("exact_cnt", int'(bus.exact_cnt), ex);
        check("present_cnt", int'(bus.present_cnt), pr);
      end
    end
    if (!seen) check("result_timeout", 0, 1);
    check("write_count", nw, 4);
    tick();
    if (ex == 4) exp_state = int'(S_WON);
    else if (m_row == 7) exp_state = int'(S_LOST);
    else begin
      exp_state = int'(S_EDIT);
      m_row++; m_cursor = 0;
      for (int s = 0; s < 4; s++) m_guess[s] = 0;
    end
    check("result_pulse", int'(bus.result_valid), 0);
    check("post_state", int'(bus.state), exp_state);
    check("post_won", int'(bus.won), int'(ex == 4));
    check("post_lost", int'(bus.lost), int'(exp_state == int'(S_LOST)));
    check("post_row", int'(bus.row), m_row);
    check("held_exact", int'(bus.exact_cnt), ex);
    if (exp_state == int'(S_EDIT)) check("post_guess", int'(bus.guess), 0);
  endtask

  task automatic make_wrong();
    bit same = 1'b1;
    for (int s = 0; s < 4; s++) if (cur_g[s] != sec[s]) same = 1'b0;
    if (same) cur_g[0] = (sec[0] + 1) % 6;
  endtask

  initial begin
    int rv_seen;
    vecs[0] = '{5'b00100, 3, 12'h000};  // left wraps 0 -> 3
    vecs[1] = '{5'b00001, 3, 12'hA00};  // down wraps 0 -> 5
    vecs[2] = '{5'b01010, 0, 12'hA00};  // right beats up
    vecs[3] = '{5'b00010, 0, 12'hA01};
    vecs[4] = '{5'b00101, 3, 12'hA01};  // left beats down
    vecs[5] = '{5'b00001, 3, 12'h801};
    vecs[6] = '{5'b00011, 3, 12'hA01};  // up beats down
    vecs[7] = '{5'b01000, 0, 12'hA01};
    vecs[8] = '{5'b00001, 0, 12'hA00};
    vecs[9] = '{5'b00001, 0, 12'hA05};

    bus.center = 1'b0; bus.right = 1'b0; bus.left = 1'b0; bus.up = 1'b0; bus.down = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_state", int'(bus.state), int'(S_IDLE));
    check("rst_regs", int'(bus.cursor) + int'(bus.row) + int'(bus.guess), 0);
    check("rst_counts", int'(bus.exact_cnt) + int'(bus.present_cnt), 0);
    check("rst_flags", {bus.won, bus.lost, bus.wr_en, bus.result_valid}, 0);

    drive(5'b00010);
    check("idle_ignores_up", int'(bus.state), int'(S_IDLE));
    check("idle_guess", int'(bus.guess), 0);

    // Game A: edit vectors, then a winning guess
    start_game();
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].btn);
      check("vec_state", int'(bus.state), int'(S_EDIT));
      check("vec_cursor", int'(bus.cursor), vecs[v].exp_cursor);
      check("vec_guess", int'(bus.guess), int'(vecs[v].exp_guess));
    end
    m_cursor = 0; m_guess[0] = 5; m_guess[1] = 0; m_guess[2] = 0; m_guess[3] = 5;
    for (int s = 0; s < 4; s++) cur_g[s] = sec[s];
    submit();
    drive(5'b01010);
    check("won_ignores_dir", int'(bus.state), int'(S_WON));
    drive(5'b10000);
    check("won_to_idle", int'(bus.state), int'(S_IDLE));
    check("won_cleared", int'(bus.won), 0);

    // Game B: random edits, permutation, all-ones, random wrong guesses, loss on row 7
    start_game();
    for (int r = 0; r < 24; r++) edit_press(5'($urandom_range(1, 15)));
    cur_g[0] = sec[1]; cur_g[1] = sec[0]; cur_g[2] = sec[3]; cur_g[3] = sec[2];
    make_wrong();
    submit();
    for (int s = 0; s < 4; s++) cur_g[s] = 1;
    make_wrong();
    submit();
    for (int g = 0; g < 5; g++) begin
      for (int s = 0; s < 4; s++) cur_g[s] = $urandom_range(0, 5);
      make_wrong();
      submit();
    end
    for (int s = 0; s < 4; s++) cur_g[s] = sec[s];
    cur_g[0] = (sec[0] + 1) % 6;
    submit();
    drive(5'b00110);
    check("lost_ignores_dir", int'(bus.state), int'(S_LOST));
    drive(5'b10000);
    check("lost_to_idle", int'(bus.state), int'(S_IDLE));
    check("lost_cleared", int'(bus.lost), 0);

    // Game C: reset in the middle of the pair scan
    start_game();
    drive(5'b10000);
    repeat (8) tick();
    check("in_present", int'(bus.state), int'(S_PRESENT));
    rst = 1'b1;
    tick();
    check("abort_state", int'(bus.state), int'(S_IDLE));
    check("abort_wr_en", int'(bus.wr_en), 0);
    check("abort_counts", int'(bus.exact_cnt) + int'(bus.present_cnt), 0);
    check("abort_rv", int'(bus.result_valid), 0);
    rst = 1'b0;
    rv_seen = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (bus.result_valid || bus.wr_en) rv_seen++;
    end
    check("abort_no_result", rv_seen, 0);
    check("abort_stays_idle", int'(bus.state), int'(S_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
